// File: rtl/ifft_butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly for the inverse transform: twiddle capture, complex multiply,
// then add/sub with optional 1/2 scaling and saturation. The whole pipe freezes on back-pressure.
module ifft_butterfly_pipe #(
    parameter int W       = 16,
    parameter bit INVERSE = 1'b1,
    parameter bit SCALE   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] xr,
    input  logic signed [W-1:0] xi,
    input  logic signed [W-1:0] yr,
    input  logic signed [W-1:0] yi,
    input  logic signed [W-1:0] wr,
    input  logic signed [W-1:0] wi,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out1r,
    output logic signed [W-1:0] out1i,
    output logic signed [W-1:0] out2r,
    output logic signed [W-1:0] out2i,
    output logic                ovf,
    input  logic                ovf_clr
);

    localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W+2:0] HI   = {3'b000, SMAX};
    localparam logic signed [W+2:0] LO   = {3'b111, SMIN};

    // Handshake: a beat moves on every edge where en is high; in_ready is en itself,
    // so an input transfers exactly when in_valid && in_ready at a rising edge.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    function automatic logic signed [2*W-1:0] mul(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
        logic signed [2*W-1:0] ae;
        logic signed [2*W-1:0] be;
        ae = {{W{a[W-1]}}, a};
        be = {{W{b[W-1]}}, b};
        return ae * be;
    endfunction

    // Drops the Q1.15 fraction: arithmetic shift, rounding toward -inf.
    function automatic logic signed [W+1:0] q_shift(input logic signed [2*W:0] a);
        return a[2*W:W-1];
    endfunction

    // Returns {saturated, value}.
    function automatic logic [W:0] scale_sat(input logic signed [W+2:0] s);
        logic signed [W+2:0] v;
        v = SCALE ? {s[W+2], s[W+2:1]} : s;
        if (v > HI)      return {1'b1, SMAX};
        else if (v < LO) return {1'b1, SMIN};
        else             return {1'b0, v[W-1:0]};
    endfunction

    // Stage 1: capture operands and the effective twiddle.
    logic                s1_valid;
    logic signed [W-1:0] s1_xr, s1_xi, s1_yr, s1_yi, s1_wr, s1_wi;
    logic signed [W-1:0] wi_eff;

    always_comb begin
        wi_eff = wi;
        if (INVERSE) wi_eff = (wi == SMIN) ? SMAX : -wi;
    end

    // Stage 2: full-precision complex multiply.
    logic signed [2*W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [2*W:0]   acc_r, acc_i;
    logic                  s2_valid;
    logic signed [W-1:0]   s2_xr, s2_xi;
    logic signed [W+1:0]   s2_pr, s2_pi;

    always_comb begin
        p_rr  = mul(s1_yr, s1_wr);
        p_ii  = mul(s1_yi, s1_wi);
        p_ri  = mul(s1_yr, s1_wi);
        p_ir  = mul(s1_yi, s1_wr);
        acc_r = {p_rr[2*W-1], p_rr} - {p_ii[2*W-1], p_ii};
        acc_i = {p_ri[2*W-1], p_ri} + {p_ir[2*W-1], p_ir};
    end

    // Stage 3: add/sub, scale, saturate.
    logic signed [W+2:0] sum1r, sum1i, sum2r, sum2i;
    logic [W:0]          r1r, r1i, r2r, r2i;
    logic                any_sat, sat_set, sat_pend;

    always_comb begin
        sum1r   = {{3{s2_xr[W-1]}}, s2_xr} + {s2_pr[W+1], s2_pr};
        sum1i   = {{3{s2_xi[W-1]}}, s2_xi} + {s2_pi[W+1], s2_pi};
        sum2r   = {{3{s2_xr[W-1]}}, s2_xr} - {s2_pr[W+1], s2_pr};
        sum2i   = {{3{s2_xi[W-1]}}, s2_xi} - {s2_pi[W+1], s2_pi};
        r1r     = scale_sat(sum1r);
        r1i     = scale_sat(sum1i);
        r2r     = scale_sat(sum2r);
        r2i     = scale_sat(sum2i);
        any_sat = r1r[W] | r1i[W] | r2r[W] | r2i[W];
        sat_set = en && s2_valid && any_sat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_xr     <= '0;
            s1_xi     <= '0;
            s1_yr     <= '0;
            s1_yi     <= '0;
            s1_wr     <= '0;
            s1_wi     <= '0;
            s2_valid  <= 1'b0;
            s2_xr     <= '0;
            s2_xi     <= '0;
            s2_pr     <= '0;
            s2_pi     <= '0;
            out_valid <= 1'b0;
            out1r     <= '0;
            out1i     <= '0;
            out2r     <= '0;
            out2i     <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_xr     <= xr;
            s1_xi     <= xi;
            s1_yr     <= yr;
            s1_yi     <= yi;
            s1_wr     <= wr;
            s1_wi     <= wi_eff;
            s2_valid  <= s1_valid;
            s2_xr     <= s1_xr;
            s2_xi     <= s1_xi;
            s2_pr     <= q_shift(acc_r);
            s2_pi     <= q_shift(acc_i);
            out_valid <= s2_valid;
            out1r     <= r1r[W-1:0];
            out1i     <= r1i[W-1:0];
            out2r     <= r2r[W-1:0];
            out2i     <= r2i[W-1:0];
        end
    end

    // A saturation coinciding with ovf_clr is parked in sat_pend and lands one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf      <= 1'b0;
            sat_pend <= 1'b0;
        end else if (ovf_clr) begin
            ovf      <= 1'b0;
            sat_pend <= sat_set || sat_pend;
        end else begin
            ovf      <= ovf || sat_set || sat_pend;
            sat_pend <= 1'b0;
        end
    end

endmodule
